// File: rtl/div_restoring_if.sv
// Request/response bundle between the execute stage and the restoring divider.
// The master drives operands and the level-held go; the slave returns results.
interface div_restoring_if;
    logic        go;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output go, sign, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  go, sign, dividend, divisor,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/div_restoring.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, with
// RISC-V divide-by-zero results and a level-held go/done handshake.
module div_restoring (
    input  logic            clk,
    input  logic            reset,
    div_restoring_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_dmag;
    logic [31:0] r_dq;
    logic [31:0] r_pr;
    logic [4:0]  r_cnt;
    logic [31:0] r_quot;
    logic [31:0] r_rem;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_pr_sh;
    logic [32:0] w_trial;
    logic        w_qbit;
    logic        w_div_zero;

    assign w_a_mag    = (bus.sign & bus.dividend[31]) ? (~bus.dividend + 32'd1) : bus.dividend;
    assign w_b_mag    = (bus.sign & bus.divisor[31])  ? (~bus.divisor + 32'd1)  : bus.divisor;
    assign w_div_zero = (bus.divisor == '0);

    // Stored remainder is always below the divisor magnitude, so 32 bits hold it;
    // the shifted value keeps its carry bit for the trial subtract.
    assign w_pr_sh = {r_pr, r_dq[31]};
    assign w_trial = w_pr_sh - {1'b0, r_dmag};
    assign w_qbit  = ~w_trial[32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_next = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (!bus.go) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                w_next = bus.go ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dmag  <= '0;
            r_dq    <= '0;
            r_pr    <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_neg_q <= bus.sign & (bus.dividend[31] ^ bus.divisor[31]);
                        r_neg_r <= bus.sign & bus.dividend[31];
                        r_dq    <= w_a_mag;
                        r_dmag  <= w_b_mag;
                        r_pr    <= '0;
                        r_cnt   <= '0;
                        if (w_div_zero) begin
                            r_quot <= '1;
                            r_rem  <= bus.dividend;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.go) begin
                        r_pr  <= w_qbit ? w_trial[31:0] : w_pr_sh[31:0];
                        r_dq  <= {r_dq[30:0], w_qbit};
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_FIXUP: begin
                    if (bus.go) begin
                        r_quot <= r_neg_q ? (~r_dq + 32'd1) : r_dq;
                        r_rem  <= r_neg_r ? (~r_pr + 32'd1) : r_pr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (r_state == S_CALC) || (r_state == S_FIXUP);
    assign bus.done      = (r_state == S_DONE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring: directed vector table, abort/reset
// sequences, and randomized back-to-back operations against an arithmetic model.
module tb_div_restoring;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_restoring_if bus ();

    div_restoring dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, tq, tr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0];
            r  = tr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output int lat, output int busy_n, output logic excl_ok);
        bit fin;
        @(negedge clk);
        bus.go       = 1'b1;
        bus.sign     = s;
        bus.dividend = a;
        bus.divisor  = b;
        lat = 0; busy_n = 0; excl_ok = 1'b1; q = '0; r = '0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (bus.busy && bus.done) excl_ok = 1'b0;
            if (bus.done) begin
                q = bus.quotient;
                r = bus.remainder;
                bus.go = 1'b0;
                fin = 1;
            end else if (lat >= 80) begin
                checks++;
                failures++;
                $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
                bus.go = 1'b0;
                fin = 1;
            end
        end
    endtask

    logic [31:0] q, r, eq, er;
    int          lat, busy_n;
    logic        excl;
    logic        saw_done;
    logic        s_rnd;
    logic [31:0] a_rnd, b_rnd;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,         32'd2,          34};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2,  32'hFFFF_FFFE,  34};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,          34};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'd0,        32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[4] = '{1'b0, 32'h8000_0000,  32'd0,        32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          34};
        vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000,  34};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0,          34};
        vecs[8] = '{1'b0, 32'd1000,       32'd3,        32'd333,        32'd1,          34};
        vecs[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF,  34};

        reset        = 1'b1;
        bus.go       = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_quotient", bus.quotient, 32'd0);
        chk("reset_remainder", bus.remainder, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].s, vecs[i].a, vecs[i].b, q, r, lat, busy_n, excl);
            chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), busy_n, (vecs[i].lat == 34) ? 33 : 0);
            chk($sformatf("vec%0d_busy_done_excl", i), {31'd0, excl}, 32'd1);
        end

        // Abort at CALC iteration 10: previous results (3, -1) must survive.
        @(negedge clk);
        bus.go = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        bus.go = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_quotient", bus.quotient, 32'd3);
        chk("abort_remainder", bus.remainder, 32'hFFFF_FFFF);
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);

        do_op(1'b0, 32'd1000, 32'd3, q, r, lat, busy_n, excl);
        chk("restart_quotient", q, 32'd333);
        chk("restart_remainder", r, 32'd1);
        chk("restart_latency", lat, 34);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.go = 1'b1; bus.sign = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset_done", {31'd0, bus.done}, 32'd0);
        chk("midreset_quotient", bus.quotient, 32'd0);
        chk("midreset_remainder", bus.remainder, 32'd0);
        bus.go = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 1200; i++) begin
            s_rnd = 1'($urandom_range(0, 1));
            a_rnd = $urandom;
            case ($urandom_range(0, 3))
                0:       b_rnd = 32'($urandom_range(1, 15));
                1:       b_rnd = $urandom >> $urandom_range(0, 31);
                default: b_rnd = $urandom;
            endcase
            if (i % 50 == 0) b_rnd = 32'd0;
            if (i == 7) begin
                s_rnd = 1'b1; a_rnd = 32'h8000_0000; b_rnd = 32'hFFFF_FFFF;
            end
            ref_div(s_rnd, a_rnd, b_rnd, eq, er);
            do_op(s_rnd, a_rnd, b_rnd, q, r, lat, busy_n, excl);
            chk($sformatf("rnd%0d_quotient s=%0d %h/%h", i, s_rnd, a_rnd, b_rnd), q, eq);
            chk($sformatf("rnd%0d_remainder s=%0d %h/%h", i, s_rnd, a_rnd, b_rnd), r, er);
            chk($sformatf("rnd%0d_latency", i), lat, (b_rnd == 32'd0) ? 1 : 34);
            chk($sformatf("rnd%0d_busy_done_excl", i), {31'd0, excl}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
